// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of (pc, instr) pairs
// with MIPS field split, immediate extension and jump target of the head.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   flush                   sync clear of all entries (push/pop ignored)
//   in_valid/in_ready       fetch push handshake, in_instr/in_pc payload
//   out_valid/out_ready     decode pop handshake
//   ext_op                  imm32 mode: 00 zero, 01 sign, 10 lui, 11 zero
//   out_instr/out_pc        head entry (zero when empty)
//   op..addr26              head instruction fields (zero when empty)
//   imm32, jtarget          extended immediate, jump target of head
//   count                   current occupancy
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [1:0]       ext_op,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      addr26,
  output logic [31:0]      imm32,
  output logic [PC_W-1:0]  jtarget,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(DEPTH);

  // Bits of pc+4 kept in a jump target.
  localparam logic [PC_W-1:0] HI_MASK =
    ~PC_W'(28'hFFF_FFFF);

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  entry_t           w_head;
  logic [PC_W-1:0]  w_pc4;
  logic [CNT_W-1:0] w_count_nx;

  assign in_ready  = (r_count != FULL);
  assign w_valid   = (r_count != '0);
  assign out_valid = w_valid;
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = w_valid & out_ready & ~flush;

  always_comb begin
    w_count_nx = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + 1'b1;
      2'b01:   w_count_nx = r_count - 1'b1;
      default: w_count_nx = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nx;
    end
  end

  // Storage carries no reset; stale slots are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr].instr <= in_instr;
      r_mem[r_wr_ptr].pc    <= in_pc;
    end
  end

  // Empty queue presents an all-zero NOP bubble.
  assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;
  assign op        = w_head.instr[31:26];
  assign rs        = w_head.instr[25:21];
  assign rt        = w_head.instr[20:16];
  assign rd        = w_head.instr[15:11];
  assign shamt     = w_head.instr[10:6];
  assign funct     = w_head.instr[5:0];
  assign imm16     = w_head.instr[15:0];
  assign addr26    = w_head.instr[25:0];

  always_comb begin
    imm32 = {16'b0, imm16};
    unique case (ext_op)
      2'b01:   imm32 = {{16{imm16[15]}}, imm16};
      2'b10:   imm32 = {imm16, 16'b0};
      default: imm32 = {16'b0, imm16};
    endcase
  end

  // Carry out of pc+4 falls off the PC_W-bit sum.
  assign w_pc4   = out_pc + PC_W'(4);
  assign jtarget = (w_pc4 & HI_MASK)
                 | PC_W'({addr26, 2'b00});

endmodule
